prog_counter_ras: RTL

Parametrised next-generation program counter for the instruction-fetch stage. It holds the current instruction address and advances it under control-unit command. Supported modes are sequential step, PC-relative branch, absolute jump, call and return. A return-address stack (RAS) of configurable depth serves call/return, and sticky error flags report misalignment and stack abuse.

---
 rtl/prog_counter_ras.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/prog_counter_ras.sv
// Purpose : instruction-fetch program counter with circular return-address stack and sticky error flags.
// Latency : 1 cycle; the new PC is visible after the rising edge that accepts a command (no input-to-output comb path).
// Backpressure: none; controlPC=0 holds PC/RAS/flags, and flagClear still applies.
//
// Ports:
//   clk, reset                   - clock, asynchronous active-high reset
//   controlPC, pcSel             - update enable and mode (0 SEQ, 1 BRANCH, 2 JUMP, 3 CALL, 4 RET, 5-7 reserved)
//   branchOffset, jumpTarget     - signed byte offset for BRANCH, absolute target for JUMP/CALL
//   flagClear                    - clears sticky flags (a same-cycle new error wins)
//   instAddress_out              - registered PC
//   rasEmpty, rasFull            - RAS occupancy, combinational from the entry count
//   rasOverflow, rasUnderflow, misalignErr, illegalSel - sticky error flags
// Optional: define PC_TRACE_EN to print a simulation trace of every accepted update and of reset.
module prog_counter_ras #(
    parameter int unsigned       ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC  = '0,
    parameter int unsigned       INST_BYTES = 4,
    parameter int unsigned       RAS_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              controlPC,
    input  logic [2:0]        pcSel,
    input  logic [ADDR_W-1:0] branchOffset,
    input  logic [ADDR_W-1:0] jumpTarget,
    input  logic              flagClear,
    output logic [ADDR_W-1:0] instAddress_out,
    output logic              rasEmpty,
    output logic              rasFull,
    output logic              rasOverflow,
    output logic              rasUnderflow,
    output logic              misalignErr,
    output logic              illegalSel
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(INST_BYTES);
    // Low address bits that must be zero; all-zero when INST_BYTES=1, which disables the check.
    localparam logic [ADDR_W-1:0] LOW_MASK = STEP - ADDR_W'(1);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(RAS_DEPTH);

    localparam logic [2:0] SEL_SEQ    = 3'd0;
    localparam logic [2:0] SEL_BRANCH = 3'd1;
    localparam logic [2:0] SEL_JUMP   = 3'd2;
    localparam logic [2:0] SEL_CALL   = 3'd3;
    localparam logic [2:0] SEL_RET    = 3'd4;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr_q, ptr_d;      // next slot to write; top entry sits at ptr_q-1
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              mis_q, mis_d;
    logic              ill_q, ill_d;

    logic              push_en;
    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] ras_top;
    logic              empty, full;
    logic              ovf_set, unf_set, mis_set, ill_set;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == FULL_CNT);
    assign seq_pc  = pc_q + STEP;
    assign ras_top = ras_q[ptr_q - PTR_W'(1)];

    always_comb begin
        pc_d    = pc_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        push_en = 1'b0;
        target  = jumpTarget;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        mis_set = 1'b0;
        ill_set = 1'b0;

        if (controlPC) begin
            case (pcSel)
                SEL_SEQ: begin
                    pc_d = seq_pc;
                end
                SEL_BRANCH, SEL_JUMP, SEL_CALL: begin
                    target  = (pcSel == SEL_BRANCH) ? (pc_q + branchOffset) : jumpTarget;
                    pc_d    = target & ~LOW_MASK;
                    mis_set = |(target & LOW_MASK);
                    if (pcSel == SEL_CALL) begin
                        push_en = 1'b1;
                        // The write pointer wraps, so a push while full lands on the oldest entry.
                        ptr_d   = ptr_q + PTR_W'(1);
                        if (full) begin
                            ovf_set = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                SEL_RET: begin
                    if (empty) begin
                        pc_d    = seq_pc;
                        unf_set = 1'b1;
                    end else begin
                        pc_d  = ras_top;
                        ptr_d = ptr_q - PTR_W'(1);
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    ill_set = 1'b1;
                end
            endcase
        end

        // A new error in the clearing cycle keeps its flag set.
        ovf_d = (flagClear ? 1'b0 : ovf_q) | ovf_set;
        unf_d = (flagClear ? 1'b0 : unf_q) | unf_set;
        mis_d = (flagClear ? 1'b0 : mis_q) | mis_set;
        ill_d = (flagClear ? 1'b0 : ill_q) | ill_set;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q  <= RESET_VEC;
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            mis_q <= 1'b0;
            ill_q <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= '0;
            end
        end else begin
            pc_q  <= pc_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
            mis_q <= mis_d;
            ill_q <= ill_d;
            if (push_en) begin
                ras_q[ptr_q] <= seq_pc;
            end
        end
    end

    assign instAddress_out = pc_q;
    assign rasEmpty        = empty;
    assign rasFull         = full;
    assign rasOverflow     = ovf_q;
    assign rasUnderflow    = unf_q;
    assign misalignErr     = mis_q;
    assign illegalSel      = ill_q;

`ifdef PC_TRACE_EN
    function automatic string mode_name(input logic [2:0] sel);
        case (sel)
            SEL_SEQ:    return "SEQ";
            SEL_BRANCH: return "BRANCH";
            SEL_JUMP:   return "JUMP";
            SEL_CALL:   return "CALL";
            SEL_RET:    return "RET";
            default:    return "RESERVED";
        endcase
    endfunction

    // Sampled in the active region of the edge, so pc_q is still the old PC and pc_d the new one.
    always @(posedge clk) begin
        if (!reset && controlPC) begin
            $display("%0t %s old_pc=%h new_pc=%h ras_count=%0d",
                     $time, mode_name(pcSel), pc_q, pc_d, cnt_d);
        end
    end

    always @(posedge reset) begin
        $display("Program starts execution at %h", RESET_VEC);
    end
`endif

endmodule
